// File: rtl/board_rst_status_ctrl.sv
// Board reset sequencer and status-LED controller.
// Debounced button + PLL-lock gated SoC reset release, exit latch, LED bank.
//
// Ports:
//   clk_gen, rst_n         clock, async active-low reset
//   btn_rst_i              raw reset button (async, active-high)
//   pll_locked_i           clock wizard lock (async)
//   sw_rst_req_i           one-cycle software reset request (clk_gen domain)
//   exit_valid_i           SoC exit valid (async)
//   exit_value_i[31:0]     SoC exit value, stable while exit_valid_i is high
//   soc_rst_no             SoC reset, active-low
//   exit_done_o            exit status latched
//   exit_code_o[31:0]      latched exit value
//   state_o[1:0]           HOLD=0, WAIT_LOCK=1, COUNT=2, RUN=3
//   led_o[NUM_LED-1:0]     status LEDs, active-high
//
// Optional: define BOARD_RST_SW_RESET_EN to let sw_rst_req_i restart the
// hold period from S_RUN. Without it the port is ignored.
module board_rst_status_ctrl #(
    parameter int NUM_LED         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int RST_HOLD_CYCLES = 1024,
    parameter int BLINK_SLOW_LOG2 = 27,
    parameter int BLINK_FAST_LOG2 = 23
) (
    input  logic               clk_gen,
    input  logic               rst_n,
    input  logic               btn_rst_i,
    input  logic               pll_locked_i,
    input  logic               sw_rst_req_i,
    input  logic               exit_valid_i,
    input  logic [31:0]        exit_value_i,
    output logic               soc_rst_no,
    output logic               exit_done_o,
    output logic [31:0]        exit_code_o,
    output logic [1:0]         state_o,
    output logic [NUM_LED-1:0] led_o
);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_COUNT     = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    if (NUM_LED < 4) begin : g_bad_num_led
        $error("NUM_LED must be at least 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (BLINK_FAST_LOG2 > BLINK_SLOW_LOG2) begin : g_bad_blink
        $error("BLINK_FAST_LOG2 must not exceed BLINK_SLOW_LOG2");
    end

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] xv_sync_q;
    logic                   btn_s;
    logic                   lock_s;
    logic                   xv_s;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
            xv_sync_q   <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_rst_i};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
            xv_sync_q   <= {xv_sync_q[SYNC_STAGES-2:0], exit_valid_i};
        end
    end

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign xv_s   = xv_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Button debounce
    // ------------------------------------------------------------------
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
        end else if (btn_s == btn_db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            // Counter value DB_LAST marks the last of the stable cycles.
            btn_db_q <= btn_s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer FSM
    // ------------------------------------------------------------------
    state_e              state_q;
    state_e              state_d;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                soc_rst_d;
    logic                soc_rst_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (btn_db_q) begin
            state_d = S_HOLD;
        end else if (!lock_s && (state_q != S_HOLD)) begin
            state_d = S_WAIT_LOCK;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
`ifdef BOARD_RST_SW_RESET_EN
                    if (sw_rst_req_i) begin
                        state_d = S_COUNT;
                    end
`endif
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_comb begin
        soc_rst_d = (state_d == S_RUN);
    end

`ifndef BOARD_RST_SW_RESET_EN
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req_i;
`endif

    // Cleared on any entry into S_COUNT, including a restart from S_RUN.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if ((state_d == S_COUNT) && (state_q != S_COUNT)) begin
            hold_cnt_q <= '0;
        end else if (state_q == S_COUNT) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            soc_rst_q <= 1'b0;
        end else begin
            soc_rst_q <= soc_rst_d;
        end
    end

    // ------------------------------------------------------------------
    // Exit status latch
    // ------------------------------------------------------------------
    logic        xv_prev_q;
    logic        xv_rise;
    logic        exit_done_q;
    logic [31:0] exit_code_q;

    assign xv_rise = xv_s & ~xv_prev_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            xv_prev_q <= 1'b0;
        end else begin
            xv_prev_q <= xv_s;
        end
    end

    // Only latches while staying in S_RUN; any exit from S_RUN clears it.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            exit_done_q <= 1'b0;
            exit_code_q <= '0;
        end else if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            if (xv_rise && !exit_done_q) begin
                exit_done_q <= 1'b1;
                exit_code_q <= exit_value_i;
            end
        end else begin
            exit_done_q <= 1'b0;
            exit_code_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Heartbeat counter
    // ------------------------------------------------------------------
    logic [BLINK_SLOW_LOG2-1:0] hb_cnt_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // LED bank
    // ------------------------------------------------------------------
    logic [31:0]        code_masked;
    logic [NUM_LED-1:0] led_code;
    logic [NUM_LED-1:0] led_d;
    logic [NUM_LED-1:0] led_q;

    assign code_masked = exit_done_q ? exit_code_q : 32'd0;

    // Exit-code bits start at LED 4; the cast drops or zero-fills the rest.
    assign led_code = NUM_LED'({code_masked, 4'b0000});

    always_comb begin
        led_d    = led_code;
        led_d[0] = soc_rst_q;
        led_d[1] = hb_cnt_q[BLINK_SLOW_LOG2-1];
        if (!exit_done_q) begin
            led_d[2] = 1'b0;
        end else if (exit_code_q == 32'd0) begin
            led_d[2] = 1'b1;
        end else begin
            led_d[2] = hb_cnt_q[BLINK_FAST_LOG2-1];
        end
        led_d[3] = lock_s;
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign soc_rst_no  = soc_rst_q;
    assign exit_done_o = exit_done_q;
    assign exit_code_o = exit_code_q;
    assign state_o     = state_q;
    assign led_o       = led_q;

endmodule

// File: tb/tb_board_rst_status_ctrl.sv
// Directed self-checking bench for board_rst_status_ctrl.
// Small parameters so the full sequence finishes in a few hundred cycles.
module tb_board_rst_status_ctrl;

    logic        clk_gen = 1'b0;
    logic        rst_n;
    logic        btn_rst_i;
    logic        pll_locked_i;
    logic        sw_rst_req_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        soc_rst_no;
    logic        exit_done_o;
    logic [31:0] exit_code_o;
    logic [1:0]  state_o;
    logic [5:0]  led_o;

    int n_checks = 0;
    int n_pass   = 0;

    board_rst_status_ctrl #(
        .NUM_LED         (6),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RST_HOLD_CYCLES (8),
        .BLINK_SLOW_LOG2 (6),
        .BLINK_FAST_LOG2 (3)
    ) dut (
        .clk_gen      (clk_gen),
        .rst_n        (rst_n),
        .btn_rst_i    (btn_rst_i),
        .pll_locked_i (pll_locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .soc_rst_no   (soc_rst_no),
        .exit_done_o  (exit_done_o),
        .exit_code_o  (exit_code_o),
        .state_o      (state_o),
        .led_o        (led_o)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_gen);
        #1;
    endtask

    task automatic ticks_until(input logic [1:0] s, input int budget,
                               output int n);
        n = 0;
        while (state_o != s && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    // Two consecutive half-periods of an LED after its next transition.
    task automatic half_periods(input int b, output int h1, output int h2);
        logic v;
        int   k;
        k = 0;
        v = led_o[b];
        while (led_o[b] == v && k < 200) begin
            tick(1);
            k++;
        end
        h1 = 0;
        v  = led_o[b];
        while (led_o[b] == v && h1 < 200) begin
            tick(1);
            h1++;
        end
        h2 = 0;
        v  = led_o[b];
        while (led_o[b] == v && h2 < 200) begin
            tick(1);
            h2++;
        end
    endtask

    initial begin
        int  n;
        int  h1;
        int  h2;
        logic solid;

        rst_n        = 1'b0;
        btn_rst_i    = 1'b0;
        pll_locked_i = 1'b1;
        sw_rst_req_i = 1'b0;
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;

        #3;
        check("rst_state", state_o, 0);
        check("rst_soc", soc_rst_no, 0);
        check("rst_done", exit_done_o, 0);
        check("rst_code", exit_code_o, 0);
        check("rst_led", led_o, 0);

        // Power-up sequence
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("pu_wait1", state_o, 1);
        tick(1);
        check("pu_wait2", state_o, 1);
        tick(1);
        check("pu_count", state_o, 2);
        tick(7);
        check("pu_count_end", state_o, 2);
        check("pu_soc_low", soc_rst_no, 0);
        tick(1);
        check("pu_run", state_o, 3);
        check("pu_soc_high", soc_rst_no, 1);
        check("pu_led0_lag", led_o[0], 0);
        tick(1);
        check("pu_led0", led_o[0], 1);
        check("pu_led3", led_o[3], 1);

        // Heartbeat
        half_periods(1, h1, h2);
        check("hb_half1", h1, 32);
        check("hb_half2", h2, 32);

        // Exit pass
        exit_value_i = 32'd0;
        exit_valid_i = 1'b1;
        tick(2);
        check("pass_done_early", exit_done_o, 0);
        tick(1);
        check("pass_done", exit_done_o, 1);
        check("pass_code", exit_code_o, 0);
        tick(1);
        solid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (led_o[2] !== 1'b1) solid = 1'b0;
            tick(1);
        end
        check("pass_led2_solid", solid, 1);
        exit_valid_i = 1'b0;

        // Short button glitch is filtered
        btn_rst_i = 1'b1;
        tick(3);
        btn_rst_i = 1'b0;
        tick(8);
        check("glitch_state", state_o, 3);
        check("glitch_done", exit_done_o, 1);

        // Held button
        btn_rst_i = 1'b1;
        tick(6);
        check("hold_pre", state_o, 3);
        tick(1);
        check("hold_state", state_o, 0);
        check("hold_soc", soc_rst_no, 0);
        check("hold_done", exit_done_o, 0);
        tick(3);
        btn_rst_i = 1'b0;
        ticks_until(2'd2, 40, n);
        check("hold_to_count", state_o, 2);
        ticks_until(2'd3, 40, n);
        check("hold_count_len", n, 8);
        check("hold_soc_up", soc_rst_no, 1);

        // Exit fail code
        exit_value_i = 32'd3;
        exit_valid_i = 1'b1;
        tick(3);
        check("fail_done", exit_done_o, 1);
        check("fail_code", exit_code_o, 3);
        tick(1);
        check("fail_led54", led_o[5:4], 2'b11);
        half_periods(2, h1, h2);
        check("fail_blink1", h1, 4);
        check("fail_blink2", h2, 4);
        exit_valid_i = 1'b0;
        tick(3);
        exit_value_i = 32'd7;
        exit_valid_i = 1'b1;
        tick(4);
        check("second_edge_code", exit_code_o, 3);
        check("second_edge_done", exit_done_o, 1);
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;

        // Lock loss
        pll_locked_i = 1'b0;
        tick(2);
        check("ll_pre", state_o, 3);
        tick(1);
        check("ll_state", state_o, 1);
        check("ll_soc", soc_rst_no, 0);
        check("ll_done", exit_done_o, 0);
        check("ll_code", exit_code_o, 0);
        check("ll_led3", led_o[3], 0);
        pll_locked_i = 1'b1;
        tick(3);
        check("ll_count", state_o, 2);
        ticks_until(2'd3, 40, n);
        check("ll_count_len", n, 8);
        check("ll_soc_up", soc_rst_no, 1);

        // Software reset
        tick(2);
        sw_rst_req_i = 1'b1;
        tick(1);
        sw_rst_req_i = 1'b0;
`ifdef BOARD_RST_SW_RESET_EN
        check("sw_state", state_o, 2);
        check("sw_soc", soc_rst_no, 0);
        ticks_until(2'd3, 40, n);
        check("sw_count_len", n, 8);
        check("sw_soc_up", soc_rst_no, 1);
`else
        check("sw_state", state_o, 3);
        check("sw_soc", soc_rst_no, 1);
        tick(10);
        check("sw_state_late", state_o, 3);
`endif

        // Asynchronous reset mid-run
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_soc", soc_rst_no, 0);
        check("ar_state", state_o, 0);
        check("ar_led", led_o, 0);
        check("ar_done", exit_done_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
